// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the serial instruction loader.
// INSTRUCTION_LOADER_CHECKSUM_EN adds the trailing checksum state.
package loader_pkg;

    localparam logic [7:0] LOADER_HEADER         = 8'hA5;
    localparam int         LOADER_BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_DATA   = 3'd3,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        ST_CHECK  = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-in / memory-write-out bundle of the instruction loader.
interface instruction_loader_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28
);
    // iRxValid is a one-cycle strobe with no ready: a byte is consumed on every
    // clock edge where iRxValid is high. oWriteEnable is a one-cycle strobe
    // with oWriteAddress/oInstruction valid in the same cycle, also without ready.
    logic [7:0]             iRxData;
    logic                   iRxValid;
    logic                   oWriteEnable;
    logic [ADDR_WIDTH-1:0]  oWriteAddress;
    logic [INSTR_WIDTH-1:0] oInstruction;
    logic                   oCpuReset;
    logic                   oDone;
    logic                   oError;

    modport master (
        output iRxData, iRxValid,
        input  oWriteEnable, oWriteAddress, oInstruction, oCpuReset, oDone, oError
    );

    modport slave (
        input  iRxData, iRxValid,
        output oWriteEnable, oWriteAddress, oInstruction, oCpuReset, oDone, oError
    );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words; word_ready pulses the cycle
// after the fourth byte of a word is shifted in.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_ready,
    output logic [1:0]  byte_idx
);
    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shift_en) begin
            shift_d = {shift_q[23:0], data};
            cnt_d   = cnt_q + 2'd1;
            ready_d = (cnt_q == 2'(LOADER_BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign word       = shift_q;
    assign word_ready = ready_q;
    assign byte_idx   = cnt_q;
endmodule

// File: rtl/instruction_loader.sv
// Serial program loader: frame parse, word packing, sequential memory writes.
// Define INSTRUCTION_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28,
    parameter int MAX_WORDS   = 256
)(
    input  logic                 Clock,
    input  logic                 Reset,
    instruction_loader_if.slave  bus,
    output loader_state_t        oDebugState
);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    localparam loader_state_t END_STATE = ST_CHECK;
    logic [7:0] csum_q, csum_d;
`else
    localparam loader_state_t END_STATE = ST_DONE;
`endif

    loader_state_t         state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_reset_q, cpu_reset_d;

    logic        asm_clear, asm_shift, asm_ready;
    logic [31:0] asm_word;
    logic [1:0]  asm_idx;
    logic        rx_hdr, last_byte, last_word;
    logic [15:0] count_now;

    word_assembler u_asm (
        .clk        (Clock),
        .rst        (Reset),
        .clear      (asm_clear),
        .shift_en   (asm_shift),
        .data       (bus.iRxData),
        .word       (asm_word),
        .word_ready (asm_ready),
        .byte_idx   (asm_idx)
    );

    assign rx_hdr    = bus.iRxValid && (bus.iRxData == LOADER_HEADER);
    assign count_now = {count_q[15:8], bus.iRxData};
    assign last_byte = (asm_idx == 2'(LOADER_BYTES_PER_WORD - 1));
    // The address has already advanced past every earlier word when a word's
    // fourth byte arrives, so it doubles as the word index here.
    assign last_word = (addr_q == ADDR_WIDTH'(count_q - 16'd1));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = asm_ready ? addr_q + 1'b1 : addr_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_reset_d = cpu_reset_q;
        asm_clear   = 1'b0;
        asm_shift   = 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        csum_d = csum_q;
        if (bus.iRxValid && (state_q == ST_CNT_HI || state_q == ST_CNT_LO || state_q == ST_DATA))
            csum_d = csum_q ^ bus.iRxData;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (rx_hdr) begin
                    state_d     = ST_CNT_HI;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cpu_reset_d = 1'b1;
                    addr_d      = '0;
                    asm_clear   = 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            ST_CNT_HI: begin
                if (bus.iRxValid) begin
                    count_d[15:8] = bus.iRxData;
                    state_d       = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (bus.iRxValid) begin
                    count_d = count_now;
                    if ({16'd0, count_now} > MAX_WORDS) state_d = ST_ERROR;
                    else if (count_now == 16'd0)        state_d = END_STATE;
                    else                                state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.iRxValid) begin
                    asm_shift = 1'b1;
                    if (last_byte && last_word) state_d = END_STATE;
                end
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.iRxValid)
                    state_d = (bus.iRxData == csum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Status flags follow the entry into the terminal states.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
        end
        if (state_d == ST_ERROR && state_q != ST_ERROR)
            error_d = 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    generate
        if (INSTR_WIDTH < 32) begin : g_trim
            logic unused_word_bits;
            assign unused_word_bits = ^asm_word[31:INSTR_WIDTH];
        end
    endgenerate

    assign bus.oWriteEnable  = asm_ready;
    assign bus.oWriteAddress = addr_q;
    assign bus.oInstruction  = asm_word[INSTR_WIDTH-1:0];
    assign bus.oCpuReset     = cpu_reset_q;
    assign bus.oDone         = done_q;
    assign bus.oError        = error_q;
    assign oDebugState       = state_q;
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Serial program loader that fills the instruction memory read by the core's fetch stage. Accepts a byte stream (one byte per `iRxValid` pulse), checks a framing header and word count, packs every four bytes into one 28-bit instruction, and issues one memory write per word at consecutive addresses. Holds the core in reset for the whole load and releases it only after a successful load.

## Interface
- `ADDR_WIDTH`, 16: instruction address width, matching the instruction pointer.
- `INSTR_WIDTH`, 28: instruction word width.
- `MAX_WORDS`, 256: largest accepted word count.
- `Clock`  in  1  system clock; all logic is on the rising edge.
- `Reset`  in  1  reset; asynchronous, active-high.
- `iRxData`  in  8  received byte.
- `iRxValid`  in  1  one-cycle strobe qualifying `iRxData`. Back-to-back strobes are allowed. There is no backpressure.
- `oWriteEnable`  out  1  one-cycle instruction-memory write strobe.
- `oWriteAddress`  out  ADDR_WIDTH  write address.
- `oInstruction`  out  INSTR_WIDTH  write data.
- `oCpuReset`  out  1  reset for the core; high while loading.
- `oDone`  out  1  high after a successful load.
- `oError`  out  1  high after a failed load.

## Operation
- Frame format: header `8'hA5`, count N (2 bytes, MSB first), N×4 data bytes, then a checksum byte when the checksum is enabled.
- Each instruction is sent big-endian. The bits of byte 0 above `INSTR_WIDTH` are discarded.
- States:
  - IDLE: on a byte equal to `8'hA5` → CNT_HI. Any other byte is ignored.
  - CNT_HI: next byte → CNT_LO.
  - CNT_LO: next byte completes N.
    - N > MAX_WORDS → ERROR.
    - N == 0 → CHECK when the checksum is enabled, otherwise DONE.
    - Otherwise → DATA.
  - DATA:
    - Sub-counter 0..3 counts bytes within a word.
    - On byte 3, the assembled word is written at the current address and the address then increments.
    - After word N-1 → CHECK (checksum enabled) or DONE.
  - CHECK: next byte compared with the running checksum. Match → DONE, mismatch → ERROR.
  - DONE: `oDone`=1, `oCpuReset`=0. A header byte → CNT_HI.
  - ERROR: `oError`=1, `oCpuReset`=1. A header byte → CNT_HI.
- Entering CNT_HI clears `oDone` and `oError`, sets `oCpuReset`=1, zeroes the address, and clears the checksum.
- Checksum: 8-bit XOR of every byte after the header (count bytes and data bytes).
- Address arithmetic is modulo 2^ADDR_WIDTH. Because MAX_WORDS ≤ 2^ADDR_WIDTH, it never wraps in practice.
- A header byte received in CNT_HI, CNT_LO, DATA or CHECK is treated as data, not as a restart.

## Timing
- Reset values: `oWriteEnable`=0, `oWriteAddress`=0, `oInstruction`=0, `oCpuReset`=1, `oDone`=0, `oError`=0, state IDLE.
- Write latency:
  - `oWriteEnable` pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted.
  - `oWriteAddress` and `oInstruction` are valid during that pulse.
  - The address increments in the cycle after the pulse.
- With strobes every cycle, the block sustains one write per 4 cycles. A strobe arriving during the write pulse is accepted normally.
- `oDone` or `oError` and the change on `oCpuReset` appear one cycle after the deciding byte.
- Reset asserted mid-load aborts immediately. Writes already issued are not undone.

## Configuration
- `INSTRUCTION_LOADER_CHECKSUM_EN` defined:
  - The trailing checksum byte is expected and the CHECK state exists.
  - On a mismatch, writes already issued remain, but the core stays in reset.
- Not defined:
  - No checksum byte is expected and the CHECK state and XOR register are absent.
  - DONE follows the last data byte, or the count bytes when N == 0.

## Structure
- Package `loader_pkg` holds:
  - the state enumeration;
  - `LOADER_HEADER = 8'hA5`;
  - the bytes-per-word constant, 4.
- Sub-module `word_assembler`:
  - a 32-bit shift register plus a 2-bit byte counter;
  - outputs the packed word and a one-cycle `word_ready`;
  - cleared when a new frame starts.

## Test plan
- Frame A5 00 02 01 23 45 67 08 9A BC DE + checksum:
  - write addr 0 data 28'h1234567;
  - write addr 1 data 28'h89ABCDE;
  - `oDone`=1, `oCpuReset`=0.
- Same frame with the checksum byte corrupted (checksum build): two writes occur, then `oError`=1 and `oCpuReset` stays 1.
- Count 0x0101 with MAX_WORDS=256: `oError`=1 after the count bytes, no writes.
- Bytes 00 FF, then A5 00 00 + checksum 00: leading bytes ignored, `oDone`=1, zero writes.
- Reset pulsed after 5 of 8 data bytes: all outputs return to their reset values; a following valid 1-word frame writes to addr 0.
- Strobe every cycle for a 3-word frame: writes spaced exactly 4 cycles apart at addrs 0, 1, 2.
